// File: rtl/mem_wb_lsu.sv
// MEM/WB stage: issues loads/stores on a req/ack bus, aligns/extends load data, drives regfile writeback.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of masking the low bits.
module mem_wb_lsu #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_mem_addr,
  input  logic [XLEN-1:0]   ex_mem_sdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              stall_req,
  output logic              mem_exc,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [XLEN-1:0]   wb_wdata
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t state, state_d;

  logic              req_d, we_d, exc_d, wb_we_d;
  logic [XLEN-1:0]   addr_d, wdata_d, wb_wdata_d;
  logic [3:0]        be_d;
  logic [REG_AW-1:0] wb_waddr_d;

  // Context of the outstanding access, needed to retire a load on ack.
  logic [2:0]        pend_f3, pend_f3_d;
  logic [1:0]        pend_off, pend_off_d;
  logic              pend_wb, pend_wb_d;
  logic [REG_AW-1:0] pend_wd, pend_wd_d;

  logic              is_mem, is_half, is_word, f3_legal, trap, go;
  logic [1:0]        off_eff;
  logic [3:0]        be_calc;
  logic [XLEN-1:0]   sdata_rep;

  always_comb begin
    is_mem   = ex_mem_rd | ex_mem_wr;
    is_half  = (ex_funct3 == F3_H) || (ex_funct3 == F3_HU);
    is_word  = (ex_funct3 == F3_W);
    f3_legal = is_half || is_word || (ex_funct3 == F3_B) || (ex_funct3 == F3_BU);
    off_eff  = ex_mem_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    trap = is_mem & (~f3_legal | (is_half & ex_mem_addr[0]) |
                     (is_word & (ex_mem_addr[1:0] != 2'b00)));
`else
    trap = is_mem & ~f3_legal;
    if (is_half) off_eff[0] = 1'b0;
    if (is_word) off_eff    = 2'b00;
`endif
    go = ex_valid & is_mem & ~trap;

    if (is_word) begin
      be_calc   = 4'b1111;
      sdata_rep = ex_mem_sdata;
    end else if (is_half) begin
      be_calc   = off_eff[1] ? 4'b1100 : 4'b0011;
      sdata_rep = {(XLEN/16){ex_mem_sdata[15:0]}};
    end else begin
      be_calc   = 4'b0001 << off_eff;
      sdata_rep = {(XLEN/8){ex_mem_sdata[7:0]}};
    end
  end

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  always_comb begin
    ld_byte = mem_rdata[{pend_off, 3'b000} +: 8];
    ld_half = mem_rdata[{pend_off[1], 4'b0000} +: 16];
    case (pend_f3)
      F3_B:    ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      F3_H:    ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Drops in the ack cycle so upstream advances exactly once per access.
  assign stall_req = ((state == IDLE) & go) | ((state == BUSY) & ~mem_ack);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state;
    req_d      = mem_req;
    we_d       = mem_we;
    addr_d     = mem_addr;
    be_d       = mem_be;
    wdata_d    = mem_wdata;
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr;
    wb_wdata_d = wb_wdata;
    exc_d      = 1'b0;
    pend_f3_d  = pend_f3;
    pend_off_d = pend_off;
    pend_wb_d  = pend_wb;
    pend_wd_d  = pend_wd;

    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (go) begin
            state_d    = BUSY;
            req_d      = 1'b1;
            we_d       = ex_mem_wr;
            addr_d     = {ex_mem_addr[XLEN-1:2], 2'b00};
            be_d       = be_calc;
            wdata_d    = sdata_rep;
            pend_f3_d  = ex_funct3;
            pend_off_d = off_eff;
            pend_wb_d  = ex_mem_rd & ex_wreg & (ex_wd != '0);
            pend_wd_d  = ex_wd;
          end else if (trap) begin
            exc_d = 1'b1;
          end else if (!is_mem) begin
            wb_we_d    = ex_wreg & (ex_wd != '0);
            wb_waddr_d = ex_wd;
            wb_wdata_d = ex_wdata;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          if (pend_wb) begin
            wb_we_d    = 1'b1;
            wb_waddr_d = pend_wd;
            wb_wdata_d = ld_ext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      wb_wdata  <= '0;
      mem_exc   <= 1'b0;
      pend_f3   <= 3'b000;
      pend_off  <= 2'b00;
      pend_wb   <= 1'b0;
      pend_wd   <= '0;
    end else begin
      state     <= state_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_be    <= be_d;
      mem_wdata <= wdata_d;
      wb_we     <= wb_we_d;
      wb_waddr  <= wb_waddr_d;
      wb_wdata  <= wb_wdata_d;
      mem_exc   <= exc_d;
      pend_f3   <= pend_f3_d;
      pend_off  <= pend_off_d;
      pend_wb   <= pend_wb_d;
      pend_wd   <= pend_wd_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Self-checking bench for mem_wb_lsu: per-cycle reference model plus directed literal expectations.
module tb_mem_wb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_wreg, ex_mem_rd, ex_mem_wr, mem_ack;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_mem_addr, ex_mem_sdata, mem_rdata;
  logic [2:0]  ex_funct3;
  logic        mem_req, mem_we, stall_req, mem_exc, wb_we;
  logic [31:0] mem_addr, mem_wdata, wb_wdata;
  logic [3:0]  mem_be;
  logic [4:0]  wb_waddr;

  always #5 clk = ~clk;

  mem_wb_lsu #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
    .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .mem_exc(mem_exc),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: access rules as plain arithmetic ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic acc_ok(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] szl;
    szl = acc_size(f3);
    if (szl == 0) return 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % szl) != 0) return 1'b0;
`endif
    return (addr == addr);
  endfunction

  function automatic logic [31:0] eff_addr(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] szl;
    szl = acc_size(f3);
    return addr - (addr % szl);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] ea);
    logic [31:0] m;
    m = ((32'd1 << acc_size(f3)) - 32'd1) << ea[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (acc_size(f3))
      1:       return (sd & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (sd & 32'h0000_FFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] ea,
                                           input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = acc_size(f3);
    v  = rd >> (8 * ea[1:0]);
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v    = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  bit          m_known = 0, m_busy = 0;
  logic        m_ld, m_wreg;
  logic [4:0]  m_wd;
  logic [2:0]  m_f3;
  logic [31:0] m_ea;
  logic        e_req, e_we, e_exc, e_wb_we;
  logic [31:0] e_addr, e_wdata, e_wb_wdata;
  logic [3:0]  e_be;
  logic [4:0]  e_wb_waddr;
  logic        s_rst, s_valid, s_wreg, s_rd, s_wr, s_ack;
  logic [4:0]  s_wd;
  logic [2:0]  s_f3;
  logic [31:0] s_wdata, s_addr, s_sdata, s_rdata;

  task automatic model_step();
    if (!s_rst) begin
      m_known = 1; m_busy = 0;
      e_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0; e_exc = 0;
      e_wb_we = 0; e_wb_waddr = 0; e_wb_wdata = 0;
    end else begin
      e_wb_we = 0;
      e_exc   = 0;
      if (m_busy) begin
        if (s_ack) begin
          m_busy = 0;
          e_req  = 0;
          if (m_ld && m_wreg && m_wd != 0) begin
            e_wb_we = 1; e_wb_waddr = m_wd; e_wb_wdata = ref_load(m_f3, m_ea, s_rdata);
          end
        end
      end else if (s_valid) begin
        if (s_rd || s_wr) begin
          if (!acc_ok(s_f3, s_addr)) e_exc = 1;
          else begin
            m_busy = 1; m_ld = s_rd; m_wreg = s_wreg; m_wd = s_wd; m_f3 = s_f3;
            m_ea   = eff_addr(s_f3, s_addr);
            e_req  = 1; e_we = s_wr; e_addr = m_ea & ~32'd3;
            e_be   = ref_be(s_f3, m_ea); e_wdata = ref_wdata(s_f3, s_sdata);
          end
        end else begin
          e_wb_we = s_wreg && (s_wd != 0); e_wb_waddr = s_wd; e_wb_wdata = s_wdata;
        end
      end
    end
  endtask

  // Compare process: inputs sampled 1 time unit before the edge, registered outputs 1 after.
  initial begin
    forever begin
      @(negedge clk); #4;
      s_rst = rst; s_valid = ex_valid; s_wreg = ex_wreg; s_rd = ex_mem_rd; s_wr = ex_mem_wr;
      s_ack = mem_ack; s_wd = ex_wd; s_f3 = ex_funct3; s_wdata = ex_wdata;
      s_addr = ex_mem_addr; s_sdata = ex_mem_sdata; s_rdata = mem_rdata;
      if (m_known)
        check("stall_req", {31'd0, stall_req},
              {31'd0, (!m_busy && s_valid && (s_rd || s_wr) && acc_ok(s_f3, s_addr)) ||
                      (m_busy && !s_ack)});
      @(posedge clk);
      model_step();
      #1;
      if (m_known) begin
        check("mem_req", {31'd0, mem_req}, {31'd0, e_req});
        check("mem_exc", {31'd0, mem_exc}, {31'd0, e_exc});
        check("wb_we",   {31'd0, wb_we},   {31'd0, e_wb_we});
        if (e_req) begin
          check("mem_we",   {31'd0, mem_we}, {31'd0, e_we});
          check("mem_addr", mem_addr, e_addr);
          check("mem_be",   {28'd0, mem_be}, {28'd0, e_be});
          if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        end
        if (e_wb_we) begin
          check("wb_waddr", {27'd0, wb_waddr}, {27'd0, e_wb_waddr});
          check("wb_wdata", wb_wdata, e_wb_wdata);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int          cap_stall;
  logic        cap_req, cap_we, cap_exc, cap_wb_we;
  logic [31:0] cap_addr, cap_wdata, cap_wb_wdata;
  logic [3:0]  cap_be;
  logic [4:0]  cap_wb_waddr;

  task automatic set_idle();
    ex_valid = 0; ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_mem_rd = 0; ex_mem_wr = 0;
    ex_funct3 = 0; ex_mem_addr = 0; ex_mem_sdata = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); set_idle(); end
  endtask

  task automatic alu(input logic [4:0] wd, input logic [31:0] wdata, input logic wreg);
    @(negedge clk); set_idle();
    ex_valid = 1; ex_wreg = wreg; ex_wd = wd; ex_wdata = wdata;
    #4 cap_stall = int'(stall_req);
    @(posedge clk); #1;
    cap_wb_we = wb_we; cap_wb_waddr = wb_waddr; cap_wb_wdata = wb_wdata;
  endtask

  // Presents a load/store and keeps it held while stalled; ack arrives in the (delay+1)th req cycle.
  task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd, input int delay,
                        input logic [31:0] rdata);
    @(negedge clk); set_idle();
    ex_valid = 1; ex_mem_rd = ld; ex_mem_wr = !ld; ex_funct3 = f3; ex_mem_addr = addr;
    ex_wdata = addr; ex_mem_sdata = sdata; ex_wd = wd; ex_wreg = ld;
    cap_stall = 0;
    #4 if (stall_req) cap_stall++;
    @(posedge clk); #1;
    cap_req = mem_req; cap_we = mem_we; cap_addr = mem_addr; cap_be = mem_be;
    cap_wdata = mem_wdata; cap_exc = mem_exc; cap_wb_we = wb_we;
    if (cap_req) begin
      for (int k = 0; k <= delay; k++) begin
        @(negedge clk);
        if (k == delay) begin mem_ack = 1; mem_rdata = rdata; end
        #4 if (stall_req) cap_stall++;
        @(posedge clk); #1;
      end
      cap_wb_we = wb_we; cap_wb_waddr = wb_waddr; cap_wb_wdata = wb_wdata;
    end
  endtask

  initial begin
    set_idle();
    rst = 0;
    repeat (3) @(negedge clk);
    #4;
    check("rst mem_req",   {31'd0, mem_req}, 32'd0);
    check("rst mem_we",    {31'd0, mem_we}, 32'd0);
    check("rst mem_be",    {28'd0, mem_be}, 32'd0);
    check("rst mem_addr",  mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst wb_we",     {31'd0, wb_we}, 32'd0);
    check("rst wb_waddr",  {27'd0, wb_waddr}, 32'd0);
    check("rst wb_wdata",  wb_wdata, 32'd0);
    check("rst mem_exc",   {31'd0, mem_exc}, 32'd0);
    check("rst stall_req", {31'd0, stall_req}, 32'd0);
    @(negedge clk); rst = 1;
    idle(1);

    alu(5'd5, 32'h0000_1234, 1'b1);
    check("alu wb_we",    {31'd0, cap_wb_we}, 32'd1);
    check("alu wb_waddr", {27'd0, cap_wb_waddr}, 32'd5);
    check("alu wb_wdata", cap_wb_wdata, 32'h0000_1234);
    check("alu stall",    cap_stall, 0);
    alu(5'd0, 32'h0000_9999, 1'b1);
    check("alu x0 wb_we", {31'd0, cap_wb_we}, 32'd0);
    alu(5'd7, 32'h0000_7777, 1'b0);
    check("alu nowreg wb_we", {31'd0, cap_wb_we}, 32'd0);

    mem_op(1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd3, 3, 32'h80FF_FF7F);
    check("lb req",    {31'd0, cap_req}, 32'd1);
    check("lb be",     {28'd0, cap_be}, 32'h8);
    check("lb addr",   cap_addr, 32'h0000_0100);
    check("lb stall",  cap_stall, 4);
    check("lb wb_we",  {31'd0, cap_wb_we}, 32'd1);
    check("lb wdata",  cap_wb_wdata, 32'hFFFF_FF80);
    check("lb waddr",  {27'd0, cap_wb_waddr}, 32'd3);

    mem_op(1'b0, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 1, 32'h0);
    check("sh we",     {31'd0, cap_we}, 32'd1);
    check("sh be",     {28'd0, cap_be}, 32'hC);
    check("sh wdata",  cap_wdata, 32'hABCD_ABCD);
    check("sh addr",   cap_addr, 32'h0000_0100);
    check("sh wb_we",  {31'd0, cap_wb_we}, 32'd0);

    mem_op(1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 0, 32'hDEAD_BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw mis req",   {31'd0, cap_req}, 32'd0);
    check("lw mis exc",   {31'd0, cap_exc}, 32'd1);
    check("lw mis stall", cap_stall, 0);
    check("lw mis wb_we", {31'd0, cap_wb_we}, 32'd0);
`else
    check("lw mis addr",  cap_addr, 32'h0000_0100);
    check("lw mis be",    {28'd0, cap_be}, 32'hF);
    check("lw mis wdata", cap_wb_wdata, 32'hDEAD_BEEF);
`endif

    // Back-to-back loads with immediate ack exercise each extension mode.
    mem_op(1'b1, 3'b100, 32'h0000_0101, 32'h0, 5'd10, 0, 32'h11A2_B3C4);
    check("lbu wdata", cap_wb_wdata, 32'h0000_00B3);
    mem_op(1'b1, 3'b000, 32'h0000_0101, 32'h0, 5'd11, 0, 32'h11A2_B3C4);
    check("lb1 wdata", cap_wb_wdata, 32'hFFFF_FFB3);
    mem_op(1'b1, 3'b101, 32'h0000_0102, 32'h0, 5'd12, 0, 32'h8001_0000);
    check("lhu wdata", cap_wb_wdata, 32'h0000_8001);
    mem_op(1'b1, 3'b001, 32'h0000_0102, 32'h0, 5'd13, 1, 32'h8001_0000);
    check("lh wdata",  cap_wb_wdata, 32'hFFFF_8001);

    mem_op(1'b1, 3'b011, 32'h0000_0100, 32'h0, 5'd14, 0, 32'h0);
    check("ill req",   {31'd0, cap_req}, 32'd0);
    check("ill exc",   {31'd0, cap_exc}, 32'd1);
    check("ill stall", cap_stall, 0);
    check("ill wb_we", {31'd0, cap_wb_we}, 32'd0);
    idle(1);

    mem_op(1'b0, 3'b000, 32'h0000_0001, 32'h1234_5678, 5'd0, 0, 32'h0);
    check("sb be",    {28'd0, cap_be}, 32'h2);
    check("sb wdata", cap_wdata, 32'h7878_7878);
    check("sb addr",  cap_addr, 32'h0000_0000);
    mem_op(1'b0, 3'b010, 32'h0000_0200, 32'hCAFE_BABE, 5'd0, 2, 32'h0);
    check("sw be",    {28'd0, cap_be}, 32'hF);
    check("sw wdata", cap_wdata, 32'hCAFE_BABE);
    mem_op(1'b0, 3'b001, 32'h0000_0103, 32'h1234_5678, 5'd0, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("sh mis exc", {31'd0, cap_exc}, 32'd1);
    check("sh mis req", {31'd0, cap_req}, 32'd0);
`else
    check("sh mis be",    {28'd0, cap_be}, 32'hC);
    check("sh mis wdata", cap_wdata, 32'h5678_5678);
`endif

    // Reset while BUSY abandons the access; a late ack must not retire anything.
    @(negedge clk); set_idle();
    ex_valid = 1; ex_mem_rd = 1; ex_wreg = 1; ex_wd = 5'd20; ex_funct3 = 3'b010;
    ex_mem_addr = 32'h0000_0300;
    @(negedge clk);
    @(negedge clk); rst = 0; set_idle();
    @(posedge clk); #1;
    check("rst busy mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); rst = 1; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    check("late ack wb_we",   {31'd0, wb_we}, 32'd0);
    check("late ack mem_req", {31'd0, mem_req}, 32'd0);

    mem_op(1'b1, 3'b010, 32'h0000_0400, 32'h0, 5'd0, 1, 32'h55AA_55AA);
    check("lw x0 req",   {31'd0, cap_req}, 32'd1);
    check("lw x0 wb_we", {31'd0, cap_wb_we}, 32'd0);

    @(negedge clk); set_idle(); mem_ack = 1; mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    check("idle ack wb_we",   {31'd0, wb_we}, 32'd0);
    check("idle ack mem_req", {31'd0, mem_req}, 32'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
